// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the memory / write-back stage
package mem_pkg;
   localparam int XLEN       = 64;
   localparam int REG_W      = 5;
   localparam int ALIGN_BITS = 3;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;
endpackage

// File: rtl/mem_wb_reg.sv
// rtl/mem_wb_reg.sv - MEM/WB pipeline register with load enable and bubble insert
module mem_wb_reg
   import mem_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             bubble,
   input  logic             d_valid,
   input  logic [XLEN-1:0]  d_read_data,
   input  logic [XLEN-1:0]  d_alu_data,
   input  logic [REG_W-1:0] d_rd,
   input  logic             d_memtoreg,
   input  logic             d_regwrite,
   output logic             wb_valid,
   output logic [XLEN-1:0]  wb_read_data,
   output logic [XLEN-1:0]  wb_alu_data,
   output logic [REG_W-1:0] wb_rd,
   output logic             wb_MemtoReg,
   output logic             wb_regwrite
);
   always_ff @(posedge clk) begin
      if (rst || (load && bubble)) begin
         wb_valid     <= 1'b0;
         wb_read_data <= '0;
         wb_alu_data  <= '0;
         wb_rd        <= '0;
         wb_MemtoReg  <= 1'b0;
         wb_regwrite  <= 1'b0;
      end else if (load) begin
         wb_valid     <= d_valid;
         wb_read_data <= d_read_data;
         wb_alu_data  <= d_alu_data;
         wb_rd        <= d_rd;
         wb_MemtoReg  <= d_memtoreg;
         wb_regwrite  <= d_regwrite;
      end
   end
endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory stage: branch resolve, data-memory handshake, MEM/WB register
module mem_wb_stage
   import mem_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [XLEN-1:0]   ALU_data,
   input  logic [XLEN-1:0]   rd_data,
   input  logic [7:0]        branch_target,
   input  logic              zero,
   input  logic [REG_W-1:0]  Rd,
   input  logic              MemtoReg,
   input  logic              regwrite,
   input  logic              branch,
   input  logic              MemRead,
   input  logic              MemWrite,
   output logic              mem_stall,
   output logic              pc_src,
   output logic [7:0]        pc_branch_target,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [XLEN-1:0]   dmem_wdata,
   input  logic              dmem_ack,
   input  logic [XLEN-1:0]   dmem_rdata,
   output logic              wb_valid,
   output logic [XLEN-1:0]   wb_read_data,
   output logic [XLEN-1:0]   wb_alu_data,
   output logic [REG_W-1:0]  wb_rd,
   output logic              wb_MemtoReg,
   output logic              wb_regwrite,
   output logic              mem_err
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [REG_W-1:0] lat_rd;
   logic             lat_memtoreg, lat_regwrite, lat_load;

   logic mem_op, illegal, start, timeout, done, abandon;
   logic load_en, bubble, d_valid, d_memtoreg, d_regwrite;
   logic [XLEN-1:0]  d_read_data, d_alu_data;
   logic [REG_W-1:0] d_rd;

   assign mem_op  = in_valid & (MemRead | MemWrite);
   assign illegal = (MemRead & MemWrite) | (ALU_data[ALIGN_BITS-1:0] != '0);
   assign start   = (state == IDLE) & mem_op & ~illegal;
   assign timeout = (cnt == CNT_W'(TIMEOUT - 1));
   assign done    = (state == WAIT) & dmem_ack;
   // ack in the final cycle beats the timeout
   assign abandon = (state == WAIT) & ~dmem_ack & timeout;

   assign mem_stall        = start | ((state == WAIT) & ~dmem_ack & ~timeout);
   assign pc_src           = (state == IDLE) & in_valid & branch & zero;
   assign pc_branch_target = branch_target;

   always_comb begin
      load_en     = (state == IDLE) | done | abandon;
      bubble      = ((state == IDLE) & mem_op) | abandon;
      d_valid     = in_valid;
      d_read_data = '0;
      d_alu_data  = ALU_data;
      d_rd        = Rd;
      d_memtoreg  = MemtoReg;
      d_regwrite  = in_valid & regwrite & (Rd != '0);
      if (state == WAIT) begin
         d_valid     = 1'b1;
         d_read_data = lat_load ? dmem_rdata : '0;
         d_alu_data  = XLEN'(dmem_addr);
         d_rd        = lat_rd;
         d_memtoreg  = lat_memtoreg;
         d_regwrite  = lat_regwrite;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         dmem_req     <= 1'b0;
         dmem_we      <= 1'b0;
         dmem_addr    <= '0;
         dmem_wdata   <= '0;
         mem_err      <= 1'b0;
         lat_rd       <= '0;
         lat_memtoreg <= 1'b0;
         lat_regwrite <= 1'b0;
         lat_load     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (mem_op && illegal) begin
                  mem_err <= 1'b1;
               end else if (start) begin
                  dmem_addr    <= ALU_data[ADDR_W-1:0];
                  dmem_wdata   <= rd_data;
                  dmem_we      <= MemWrite;
                  dmem_req     <= 1'b1;
                  cnt          <= '0;
                  lat_rd       <= Rd;
                  lat_memtoreg <= MemtoReg;
                  lat_regwrite <= regwrite & (Rd != '0);
                  lat_load     <= MemRead;
                  state        <= WAIT;
               end
            end
            WAIT: begin
               if (dmem_ack) begin
                  dmem_req <= 1'b0;
                  state    <= IDLE;
               end else if (timeout) begin
                  dmem_req <= 1'b0;
                  mem_err  <= 1'b1;
                  state    <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   mem_wb_reg u_mem_wb_reg (
      .clk          (clk),
      .rst          (rst),
      .load         (load_en),
      .bubble       (bubble),
      .d_valid      (d_valid),
      .d_read_data  (d_read_data),
      .d_alu_data   (d_alu_data),
      .d_rd         (d_rd),
      .d_memtoreg   (d_memtoreg),
      .d_regwrite   (d_regwrite),
      .wb_valid     (wb_valid),
      .wb_read_data (wb_read_data),
      .wb_alu_data  (wb_alu_data),
      .wb_rd        (wb_rd),
      .wb_MemtoReg  (wb_MemtoReg),
      .wb_regwrite  (wb_regwrite)
   );
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory stage plus MEM/WB pipeline register of the 5-stage RV64 pipeline; consumes the EX/MEM register outputs directly.
- Resolves taken branches.
- Performs data-memory loads and stores over a req/ack handshake with variable latency, stalling upstream while a load or store is outstanding.
- Registers write-back data, rd and control for the WB stage and the forwarding unit.

Parameters:
- ADDR_W, 10, data-memory byte-address width taken from ALU_data[ADDR_W-1:0].
- TIMEOUT, 16, maximum WAIT cycles without dmem_ack before the access is abandoned.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  EX/MEM holds a real instruction; 0 means bubble.
- ALU_data  in  64  address for load/store, or result for ALU ops.
- rd_data  in  64  store data.
- branch_target  in  8  branch PC.
- zero  in  1  ALU zero flag.
- Rd  in  5  destination register.
- MemtoReg, regwrite, branch, MemRead, MemWrite  in  1 each  control signals from EX/MEM.
- mem_stall  out  1  hold the PC, IF/ID, ID/EX and EX/MEM registers.
- pc_src  out  1  branch taken.
- pc_branch_target  out  8  target PC when pc_src=1.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  ADDR_W  request address.
- dmem_wdata  out  64  write data.
- dmem_ack  in  1  request done; dmem_rdata is valid in this cycle.
- dmem_rdata  in  64  read data.
- wb_valid  out  1  MEM/WB holds a real instruction.
- wb_read_data  out  64  load result.
- wb_alu_data  out  64  ALU result.
- wb_rd  out  5  destination register (MEM_WB_rd, also sent to the forwarding unit).
- wb_MemtoReg, wb_regwrite  out  1 each  write-back control.
- mem_err  out  1  sticky error flag.

Behaviour:
- Reset: state=IDLE; timeout counter=0; all registered outputs 0 (dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_*, mem_err). A reset during WAIT abandons the access; dmem_req falls at that edge.
- FSM states: IDLE, WAIT.
- Memory op = in_valid & (MemRead | MemWrite).
- IDLE, no memory op:
  - mem_stall=0.
  - On the next edge, MEM/WB loads: wb_valid=in_valid; wb_alu_data=ALU_data; wb_rd=Rd; wb_MemtoReg=MemtoReg; wb_regwrite=in_valid & regwrite & (Rd!=0); wb_read_data=0.
  - Latency is 1 cycle.
- IDLE, legal memory op:
  - mem_stall=1 combinationally in the same cycle.
  - On the edge: latch Rd and the control bits; dmem_addr <= ALU_data[ADDR_W-1:0]; dmem_wdata <= rd_data; dmem_we <= MemWrite; dmem_req <= 1; counter <= 0; go to WAIT.
  - MEM/WB loads a bubble (wb_valid=0, wb_regwrite=0).
- Illegal memory op: MemRead & MemWrite both 1, or ALU_data[2:0] != 0 (misaligned).
  - No request is issued and there is no stall.
  - mem_err <= 1; MEM/WB loads a bubble.
- WAIT:
  - dmem_req, dmem_addr, dmem_wdata and dmem_we are held stable.
  - mem_stall = ~dmem_ack.
  - Each cycle without ack: counter increments.
- WAIT, dmem_ack=1:
  - On the edge: dmem_req <= 0; go to IDLE.
  - MEM/WB loads the latched instruction: wb_valid=1; wb_read_data=dmem_rdata (load) or 0 (store); wb_alu_data=latched address zero-extended to 64 bits; write-back control from the latched bits.
  - Because stall is already low in the ack cycle, upstream advances on the same edge.
  - Minimum load/store latency: 2 cycles from arrival to MEM/WB.
- WAIT, counter reaches TIMEOUT-1 with no ack:
  - On the edge: dmem_req <= 0; mem_err <= 1; go to IDLE.
  - MEM/WB loads a bubble; stall releases in that cycle.
  - If ack arrives in that same cycle, ack wins and there is no error.
- Branch resolution (combinational, IDLE only):
  - pc_src = in_valid & branch & zero.
  - pc_branch_target = branch_target.
  - pc_src is forced 0 in WAIT.
- mem_err: cleared only by rst.

Decomposition:
- Shared package mem_pkg: FSM state encoding (IDLE, WAIT), XLEN=64, REG_W=5, ALIGN_BITS=3.
- The MEM/WB register is a natural sub-module, mem_wb_reg: load-enable and bubble-insert inputs, synchronous reset. The FSM, stall and branch logic stay in the top.

Test Plan:
- ALU op, in_valid=1, ALU_data=0x2A, Rd=5, regwrite=1 -> next cycle wb_valid=1, wb_alu_data=0x2A, wb_rd=5, wb_regwrite=1; mem_stall never 1.
- Load ALU_data=0x40, Rd=7, MemRead=1, MemtoReg=1; ack after 3 WAIT cycles with rdata=0xDEAD -> mem_stall=1 in the arrival cycle and the first 2 WAIT cycles, 0 in the ack cycle; dmem_req high for 3 cycles with addr=0x40; after the ack edge wb_read_data=0xDEAD, wb_rd=7.
- Store ALU_data=0x08, rd_data=0x1234, MemWrite=1; ack in first WAIT cycle -> dmem_we=1, wdata=0x1234; wb_regwrite=0; total 2 cycles.
- branch=1, zero=1, branch_target=0x3C -> pc_src=1, pc_branch_target=0x3C in the same cycle; with zero=0 -> pc_src=0.
- Load with no ack, TIMEOUT=16 -> req drops after 16 WAIT cycles, mem_err=1, bubble written. A separate load with ack on the final cycle -> no error.
- Load with ALU_data=0x41 -> no req, mem_err=1. Load with rst asserted in the 2nd WAIT cycle -> next cycle req=0, all wb_* = 0, state IDLE. Load with Rd=0 -> wb_regwrite=0.
